// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the I-cache refill
// path and the D-cache refill/write-back path. Transfers are serialised with
// a level handshake, ties are broken round-robin, and each port keeps a
// saturating grant counter for performance reporting.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] i_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_done,
  output logic [LINE_W-1:0] d_rdata,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack,

  output logic [CNT_W-1:0]  i_grants,
  output logic [CNT_W-1:0]  d_grants
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;

  state_t state;
  port_t  owner;
  port_t  last;

  logic grant_i;
  logic grant_d;

  // Arbitration: a lone request wins; on a tie the port not served last wins.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (d_req && (!i_req || last == PORT_I)) begin
      grant_d = 1'b1;
    end else if (i_req) begin
      grant_i = 1'b1;
    end
  end

  // Transfer FSM with all outputs registered.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the data registers are plain flops rather than a memory, so
      // clearing them here is cheap and gives a known reset image.
      state     <= IDLE;
      owner     <= PORT_I;
      last      <= PORT_D;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_grants  <= '0;
      d_grants  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            owner     <= PORT_I;
            last      <= PORT_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            if (i_grants != '1) i_grants <= i_grants + CNT_W'(1);
            state     <= BUSY;
          end else if (grant_d) begin
            owner     <= PORT_D;
            last      <= PORT_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (d_grants != '1) d_grants <= d_grants + CNT_W'(1);
            state     <= BUSY;
          end
        end
        BUSY: begin
          // Owner's request may drop here; the transfer still runs to done.
          if (mem_ack) begin
            if (owner == PORT_I) begin
              i_rdata <= mem_rdata;
              i_done  <= 1'b1;
            end else begin
              if (!mem_we) d_rdata <= mem_rdata;
              d_done <= 1'b1;
            end
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= RESP;
          end
        end
        RESP: begin
          i_done <= 1'b0;
          d_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
